// File: rtl/lu_fwd_subst.sv
// Forward substitution L*y = b for a unit-lower-triangular L, one multiply-accumulate per cycle.
// L and b are loaded through a write port; y is read back by index through a registered read port.
module lu_fwd_subst #(
   parameter int N = 8,
   parameter int W = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wr,
   input  logic                wr_sel,
   input  logic [15:0]         wr_addr,
   input  logic signed [W-1:0] din,
   input  logic                start,
   input  logic [7:0]          rd_addr,
   output logic signed [W-1:0] y,
   output logic                busy,
   output logic                finish
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int LW = (N > 1) ? $clog2(N * N) : 1;
   localparam logic [15:0]   L_SIZE = 16'(N * N);
   localparam logic [15:0]   B_SIZE = 16'(N);
   localparam logic [7:0]    Y_SIZE = 8'(N);
   localparam logic [IW-1:0] LAST   = IW'(N - 1);

   typedef enum logic [2:0] {IDLE, ROW_INIT, MAC, WRITE, DONE} state_t;

   state_t              state;
   logic [IW-1:0]       i, j;
   logic signed [W-1:0] acc;
   logic signed [W-1:0] l_mem [N*N];
   logic signed [W-1:0] b_mem [N];
   logic signed [W-1:0] y_mem [N];
   logic [LW-1:0]       l_rd_idx;

   // A W-bit product context keeps exactly the low W bits of the full 2W-bit product.
   function automatic logic signed [W-1:0] mac_step(input logic signed [W-1:0] a,
                                                    input logic signed [W-1:0] l,
                                                    input logic signed [W-1:0] yv);
      logic signed [W-1:0] prod;
      prod = l * yv;
      return a - prod;
   endfunction

   assign l_rd_idx = LW'(int'(i) * N + int'(j));

   always_ff @(posedge clk) begin
      if (wr && !busy) begin
         if (!wr_sel && (wr_addr < L_SIZE))
            l_mem[wr_addr[LW-1:0]] <= din;
         else if (wr_sel && (wr_addr < B_SIZE))
            b_mem[wr_addr[IW-1:0]] <= din;
      end
   end

   always_ff @(posedge clk) begin
      case (state)
         ROW_INIT: acc <= b_mem[i];
         MAC:      acc <= mac_step(acc, l_mem[l_rd_idx], y_mem[j]);
         default:  ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         i      <= '0;
         j      <= '0;
         busy   <= 1'b0;
         finish <= 1'b0;
         y      <= '0;
         for (int k = 0; k < N; k++)
            y_mem[k] <= '0;
      end else begin
         y <= (rd_addr < Y_SIZE) ? y_mem[rd_addr[IW-1:0]] : '0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state  <= ROW_INIT;
                  i      <= '0;
                  busy   <= 1'b1;
                  finish <= 1'b0;
               end
            end
            ROW_INIT: begin
               j     <= '0;
               state <= (i == '0) ? WRITE : MAC;
            end
            MAC: begin
               j <= j + IW'(1);
               if (j == i - IW'(1))
                  state <= WRITE;
            end
            WRITE: begin
               y_mem[i] <= acc;
               if (i == LAST) begin
                  state  <= DONE;
                  busy   <= 1'b0;
                  finish <= 1'b1;
               end else begin
                  i     <= i + IW'(1);
                  state <= ROW_INIT;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lu_fwd_subst.sv
// Directed bench for lu_fwd_subst: hand-computed solutions of small 8x8 systems,
// latency, wrap-around arithmetic, asynchronous reset and ignored inputs while busy.
module tb_lu_fwd_subst;
   localparam int N = 8;
   localparam int W = 32;

   logic                clk = 1'b0;
   logic                reset;
   logic                wr;
   logic                wr_sel;
   logic [15:0]         wr_addr;
   logic signed [W-1:0] din;
   logic                start;
   logic [7:0]          rd_addr;
   logic signed [W-1:0] y;
   logic                busy;
   logic                finish;

   int vectors = 0;
   int miscompares = 0;

   logic signed [W-1:0] lm [N][N];
   logic signed [W-1:0] bm [N];
   logic signed [W-1:0] ex [N];

   always #5 clk = ~clk;

   lu_fwd_subst #(.N(N), .W(W)) dut (
      .clk(clk), .reset(reset), .wr(wr), .wr_sel(wr_sel), .wr_addr(wr_addr), .din(din),
      .start(start), .rd_addr(rd_addr), .y(y), .busy(busy), .finish(finish)
   );

   task automatic wr_word(input logic sel, input int addr, input logic signed [W-1:0] val);
      @(negedge clk);
      wr = 1'b1; wr_sel = sel; wr_addr = 16'(addr); din = val;
      @(posedge clk);
      #1 wr = 1'b0;
   endtask

   task automatic load_all();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            wr_word(1'b0, r * N + c, lm[r][c]);
      for (int k = 0; k < N; k++)
         wr_word(1'b1, k, bm[k]);
   endtask

   task automatic clear_model();
      for (int r = 0; r < N; r++) begin
         bm[r] = '0;
         for (int c = 0; c < N; c++)
            lm[r][c] = '0;
      end
   endtask

   // Leaves the bench at the negedge following the edge that samples start.
   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!finish && n < 200) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
   endtask

   task automatic read_y(input int a, output logic signed [W-1:0] v);
      @(negedge clk);
      rd_addr = 8'(a);
      @(posedge clk);
      @(negedge clk);
      v = y;
   endtask

   task automatic test_reset();
      logic signed [W-1:0] v;
      #12;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0b want 0", busy); end
      vectors++; if (finish !== 1'b0) begin miscompares++; $display("FAIL reset_finish got %0b want 0", finish); end
      vectors++; if (y !== '0) begin miscompares++; $display("FAIL reset_y got %0h want 0", y); end
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < N; k += 7) begin
         read_y(k, v);
         vectors++; if (v !== '0) begin miscompares++; $display("FAIL reset_ymem[%0d] got %0h want 0", k, v); end
      end
   endtask

   task automatic test_identity();
      int n;
      logic signed [W-1:0] v;
      for (int r = 0; r < N; r++) begin
         bm[r] = r + 1;
         for (int c = 0; c < N; c++)
            lm[r][c] = (r == c) ? 5 : ((c > r) ? 123 : 0);
      end
      load_all();
      do_start();
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL ident_busy_rise got %0b want 1", busy); end
      wait_done(n);
      vectors++; if (n !== 44) begin miscompares++; $display("FAIL ident_latency got %0d want 44", n); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ident_busy_fall got %0b want 0", busy); end
      for (int k = 0; k < N; k++) begin
         read_y(k, v);
         vectors++; if (v !== k + 1) begin miscompares++; $display("FAIL ident_y[%0d] got %0d want %0d", k, v, k + 1); end
      end
   endtask

   task automatic test_all_ones();
      int n;
      logic signed [W-1:0] v;
      for (int r = 0; r < N; r++) begin
         bm[r] = 1;
         for (int c = 0; c < N; c++)
            lm[r][c] = (c <= r) ? 1 : 0;
      end
      ex = '{1, 0, 0, 0, 0, 0, 0, 0};
      load_all();
      do_start();
      wait_done(n);
      vectors++; if (n !== 44) begin miscompares++; $display("FAIL ones_latency got %0d want 44", n); end
      for (int k = 0; k < N; k++) begin
         read_y(k, v);
         vectors++; if (v !== ex[k]) begin miscompares++; $display("FAIL ones_y[%0d] got %0d want %0d", k, v, ex[k]); end
      end
   endtask

   task automatic test_wrap();
      int n;
      logic signed [W-1:0] v;
      clear_model();
      lm[1][0] = 32'h0001_0000;
      bm[0]    = 32'h0001_0000;
      load_all();
      do_start();
      wait_done(n);
      read_y(0, v);
      vectors++; if (v !== 32'h0001_0000) begin miscompares++; $display("FAIL wrap1_y0 got %0h want 10000", v); end
      read_y(1, v);
      vectors++; if (v !== 32'h0000_0000) begin miscompares++; $display("FAIL wrap1_y1 got %0h want 0", v); end
      wr_word(1'b0, 1 * N + 0, 32'hFFFF_FFFF);
      wr_word(1'b1, 0, 32'h7FFF_FFFF);
      wr_word(1'b1, 1, 32'h0000_0001);
      do_start();
      wait_done(n);
      read_y(1, v);
      vectors++; if (v !== 32'h8000_0000) begin miscompares++; $display("FAIL wrap2_y1 got %0h want 80000000", v); end
   endtask

   task automatic test_mixed();
      int n;
      logic signed [W-1:0] v;
      clear_model();
      lm[1][0] = 2; lm[2][0] = -1; lm[2][1] = 3;
      bm = '{4, 10, 7, 3, 0, 0, 0, -9};
      ex = '{4, 2, 5, 3, 0, 0, 0, -9};
      load_all();
      do_start();
      wait_done(n);
      vectors++; if (finish !== 1'b1) begin miscompares++; $display("FAIL mixed_finish got %0b want 1", finish); end
      for (int k = 0; k < N; k++) begin
         read_y(k, v);
         vectors++; if (v !== ex[k]) begin miscompares++; $display("FAIL mixed_y[%0d] got %0d want %0d", k, v, ex[k]); end
      end
      read_y(8, v);
      vectors++; if (v !== '0) begin miscompares++; $display("FAIL mixed_rd_oob got %0d want 0", v); end
      read_y(255, v);
      vectors++; if (v !== '0) begin miscompares++; $display("FAIL mixed_rd_max got %0d want 0", v); end
   endtask

   task automatic test_reset_mid();
      int n;
      logic signed [W-1:0] v;
      ex = '{4, 2, 5, 3, 0, 0, 0, -9};
      rd_addr = 8'd0;
      do_start();
      repeat (20) @(posedge clk);
      @(negedge clk);
      vectors++; if (y !== 4) begin miscompares++; $display("FAIL rstmid_partial_y0 got %0d want 4", y); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rstmid_busy_before got %0b want 1", busy); end
      #2 reset = 1'b1;
      #1;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy got %0b want 0", busy); end
      vectors++; if (finish !== 1'b0) begin miscompares++; $display("FAIL rstmid_finish got %0b want 0", finish); end
      vectors++; if (y !== '0) begin miscompares++; $display("FAIL rstmid_y got %0d want 0", y); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < N; k++) begin
         read_y(k, v);
         vectors++; if (v !== '0) begin miscompares++; $display("FAIL rstmid_cleared_y[%0d] got %0d want 0", k, v); end
      end
      do_start();
      wait_done(n);
      vectors++; if (n !== 44) begin miscompares++; $display("FAIL rstmid_latency got %0d want 44", n); end
      for (int k = 0; k < N; k++) begin
         read_y(k, v);
         vectors++; if (v !== ex[k]) begin miscompares++; $display("FAIL rstmid_y[%0d] got %0d want %0d", k, v, ex[k]); end
      end
   endtask

   task automatic test_busy_ignore();
      int n;
      logic signed [W-1:0] v;
      ex = '{4, 2, 5, 3, 0, 0, 0, -9};
      // Out-of-range addresses would alias onto b[0] and L[1][0] if not rejected.
      wr_word(1'b1, 8, 555);
      wr_word(1'b0, N * N + N, 555);
      do_start();
      n = 0;
      while (!finish && n < 200) begin
         if (n == 5) begin
            start = 1'b1; wr = 1'b1; wr_sel = 1'b1; wr_addr = 16'd0; din = 99;
         end else begin
            start = 1'b0; wr = 1'b0;
         end
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      start = 1'b0; wr = 1'b0;
      vectors++; if (n !== 44) begin miscompares++; $display("FAIL busy_latency got %0d want 44", n); end
      for (int k = 0; k < N; k++) begin
         read_y(k, v);
         vectors++; if (v !== ex[k]) begin miscompares++; $display("FAIL busy_y[%0d] got %0d want %0d", k, v, ex[k]); end
      end
      do_start();
      vectors++; if (finish !== 1'b0) begin miscompares++; $display("FAIL busy_finish_clear got %0b want 0", finish); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL busy_restart got %0b want 1", busy); end
      wait_done(n);
      vectors++; if (n !== 44) begin miscompares++; $display("FAIL busy_latency2 got %0d want 44", n); end
      read_y(0, v);
      vectors++; if (v !== 4) begin miscompares++; $display("FAIL busy_b0_kept got %0d want 4", v); end
   endtask

   task automatic test_wr_start_same();
      int n;
      logic signed [W-1:0] v;
      ex = '{6, -2, 19, 3, 0, 0, 0, -9};
      @(negedge clk);
      wr = 1'b1; wr_sel = 1'b1; wr_addr = 16'd0; din = 6; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      wr = 1'b0; start = 1'b0;
      wait_done(n);
      vectors++; if (n !== 44) begin miscompares++; $display("FAIL same_latency got %0d want 44", n); end
      for (int k = 0; k < 3; k++) begin
         read_y(k, v);
         vectors++; if (v !== ex[k]) begin miscompares++; $display("FAIL same_y[%0d] got %0d want %0d", k, v, ex[k]); end
      end
   endtask

   initial begin
      reset = 1'b1; wr = 1'b0; wr_sel = 1'b0; wr_addr = '0; din = '0; start = 1'b0; rd_addr = '0;
      test_reset();
      test_identity();
      test_all_ones();
      test_wrap();
      test_mixed();
      test_reset_mid();
      test_busy_ignore();
      test_wr_start_same();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/lu_fwd_subst.md
# lu_fwd_subst

Forward-substitution stage sitting directly downstream of the LU decomposition block. Takes the unit-lower-triangular factor L and a right-hand-side vector b, and computes y such that L·y = b (y[i] = b[i] − Σ_{j<i} L[i][j]·y[j]). Results are read back by address for the following back-substitution stage. One multiply-accumulate per cycle, fully sequential.

## Interface
- N, 8, matrix dimension (1..64)
- W, 32, data width, signed two's complement
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears the FSM, outputs and y storage
- wr  in  1  write strobe for L/b storage, sampled on clk
- wr_sel  in  1  0 = write L, 1 = write b
- wr_addr  in  16  L: row·N+col; b: index
- din  in  W  write data
- start  in  1  single-cycle start pulse
- rd_addr  in  8  y read index
- y  out  W  registered read data, y[rd_addr]
- busy  out  1  computation in progress
- finish  out  1  sticky done flag

## Operation
- Storage: L[N][N], b[N], y[N], each W bits. L and b are not reset; y is cleared to 0 by reset.
- L diagonal is treated as 1 regardless of its stored value. Entries with col > row are never read.
- Writes: accepted only when busy=0. L writes with wr_addr ≥ N·N, or b writes with wr_addr ≥ N, are ignored.
- Arithmetic: product L·y is the full 2W-bit result truncated to the low W bits. Accumulator is W bits and wraps modulo 2^W; there is no saturation and no overflow flag.
- FSM states and transitions:
  - IDLE: start=1 → ROW_INIT with i=0, busy←1, finish←0.
  - ROW_INIT: acc←b[i], j←0. If i=0 → WRITE, else → MAC.
  - MAC: acc←acc − L[i][j]·y[j], j←j+1. If j=i−1 → WRITE, else stay in MAC.
  - WRITE: y[i]←acc. If i=N−1 → DONE (busy←0, finish←1), else i←i+1 → ROW_INIT.
  - DONE: behaves as IDLE. finish stays 1 until the next accepted start or reset.
- start while busy=1 is ignored.
- wr and start in the same idle cycle: the write commits and start is accepted. The computation uses the newly written value.
- Read port: y ← y_mem[rd_addr] on every clock. rd_addr ≥ N returns 0. Reads during busy return the current (partial) contents.

## Timing
- Reset values: y=0, busy=0, finish=0, state=IDLE, all y_mem entries 0.
- Reset takes effect immediately (asynchronous). Reset mid-computation aborts it; L and b are preserved.
- Row i takes 2+i cycles. Total latency is 2N + N(N−1)/2 cycles, measured from the edge that samples start to the edge that sets finish. For N=8 this is 44; for N=1 it is 2.
- busy rises on the edge that samples start. busy falls and finish rises on the same edge.
- y[i] is written on its WRITE edge and is visible on the y output one cycle after rd_addr is applied.
- Read latency is 1 cycle at all times.

## Test plan
- **Identity case:** N=8, L strictly-lower entries all 0, diagonal written as 5, b=1..8, pulse start → finish after exactly 44 cycles, y[0..7]=1..8 (diagonal ignored).
- **All-ones lower triangle:** all lower-triangle entries 1, b all 1 → y=[1,0,0,0,0,0,0,0].
- **Mixed signs:** L[1][0]=2, L[2][0]=−1, L[2][1]=3, other off-diagonals 0; b=[4,10,7,3,0,0,0,−9] → y=[4,2,5,3,0,0,0,−9]. Read rd_addr=8 → 0.
- **Wrap-around:** L[1][0]=0x00010000, b[0]=0x00010000, b[1]=0 → y[1]=0x00000000 (product truncated). With L[1][0]=0xFFFFFFFF (−1), b[0]=0x7FFFFFFF, b[1]=1 → y[1]=0x80000000.
- **Reset mid-run:** assert reset at cycle 20 after start → busy, finish and y drop to 0 immediately and every y read returns 0. Restart after release → correct results from the retained L and b, finish after 44 cycles.
- **Ignored inputs while busy:** during busy, pulse start and write b[0]=99 → finish still at cycle 44, results computed from the original b. After finish, b[0] reads back unchanged in the next run, and the next start clears finish on the accepting edge.
